dual_issue_scoreboard_ctrl: RTL and testbench

- Issue/hazard controller between the fetch pair buffer and two decode_unit slots of the dual-issue front end.
- Keeps a per-register busy scoreboard for the 8-entry register file.
- Decides each cycle which of two in-order candidate instructions may issue, and drives the decode stall and flush controls.
- Clears busy bits from two writeback ports. Sequences a branch-flush bubble and counts stall cycles for performance monitoring.

---
 rtl/front_end_pkg.sv | 55 +++++
 rtl/issue_slot_check.sv | 40 ++++
 rtl/dual_issue_scoreboard_ctrl.sv | 119 +++++++++++
 tb/tb_dual_issue_scoreboard_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/front_end_pkg.sv
// Shared front-end definitions: instruction field layout, opcode classes
// and the issue controller state encoding.
package front_end_pkg;

    localparam int INSTR_W   = 16;
    localparam int REG_IDX_W = 3;

    localparam int OPC_LSB = 12;
    localparam int IMM_BIT = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 5;
    localparam int RS2_LSB = 2;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_STORE  = 4'hB;
    localparam logic [3:0] OP_BRANCH = 4'hC;
    localparam logic [3:0] OP_JUMP   = 4'hD;

    typedef enum logic {ST_RUN, ST_FLUSH} fsm_state_e;

    typedef struct packed {
        logic [3:0]           opc;
        logic                 imm;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
    } instr_t;

    function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] w);
        instr_t f;
        f.opc = w[OPC_LSB +: 4];
        f.imm = w[IMM_BIT];
        f.rd  = w[RD_LSB  +: REG_IDX_W];
        f.rs1 = w[RS1_LSB +: REG_IDX_W];
        f.rs2 = w[RS2_LSB +: REG_IDX_W];
        return f;
    endfunction

    function automatic logic writes_rd(input logic [3:0] opc);
        return !(opc == OP_NOP || opc == OP_STORE || opc == OP_BRANCH || opc == OP_JUMP);
    endfunction

    function automatic logic uses_rs1(input logic [3:0] opc);
        return !(opc == OP_NOP || opc == OP_JUMP);
    endfunction

    function automatic logic uses_rs2(input logic [3:0] opc, input logic imm);
        return (!imm || opc == OP_STORE) && !(opc == OP_NOP || opc == OP_JUMP);
    endfunction

    function automatic logic is_ctl(input logic [3:0] opc);
        return opc == OP_BRANCH || opc == OP_JUMP;
    endfunction

endpackage

// File: rtl/issue_slot_check.sv
// Combinational hazard check for one issue slot against a busy vector and,
// optionally, the older instruction issuing alongside it.
module issue_slot_check
    import front_end_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic [NREGS-1:0] busy,
    input  instr_t           instr,
    input  logic             prev_en,
    input  instr_t           prev,
    output logic             clean
);

    logic w, r1, r2, rd_src, rd_touch;
    logic busy_haz, prev_w, prev_ctl, pair_haz;

    always_comb begin
        w        = writes_rd(instr.opc);
        r1       = uses_rs1(instr.opc);
        r2       = uses_rs2(instr.opc, instr.imm);
        // STORE sources its data from the rd field
        rd_src   = (instr.opc == OP_STORE);
        rd_touch = w | rd_src;

        busy_haz = (r1 & busy[instr.rs1]) |
                   (r2 & busy[instr.rs2]) |
                   (rd_touch & busy[instr.rd]);

        prev_w   = prev_en & writes_rd(prev.opc);
        prev_ctl = prev_en & is_ctl(prev.opc);
        pair_haz = prev_ctl |
                   (prev_w & ((r1 & (instr.rs1 == prev.rd)) |
                              (r2 & (instr.rs2 == prev.rd)) |
                              (rd_touch & (instr.rd == prev.rd))));

        clean = !busy_haz && !pair_haz;
    end

endmodule

// File: rtl/dual_issue_scoreboard_ctrl.sv
// Dual-issue hazard controller: register busy scoreboard, in-order pair
// issue decision, branch-flush bubble sequencing and stall cycle counter.
module dual_issue_scoreboard_ctrl
    import front_end_pkg::*;
#(
    parameter int NREGS        = 8,
    parameter int FLUSH_CYCLES = 1,
    parameter int WB_BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in0_valid,
    input  logic [INSTR_W-1:0]   in0_instr,
    input  logic                 in1_valid,
    input  logic [INSTR_W-1:0]   in1_instr,
    input  logic                 is_branch_taken,
    input  logic                 wb0_valid,
    input  logic [REG_IDX_W-1:0] wb0_rd,
    input  logic                 wb1_valid,
    input  logic [REG_IDX_W-1:0] wb1_rd,
    output logic                 issue0,
    output logic                 issue1,
    output logic                 stall,
    output logic                 flush,
    output logic [NREGS-1:0]     busy_vec,
    output logic [15:0]          stall_cycles
);

    localparam int NUM_SLOTS = 2;

    fsm_state_e             state;
    logic [2:0]             flush_cnt;
    logic [NREGS-1:0]       wb_mask, set_mask, eff_busy;
    instr_t [NUM_SLOTS-1:0] slot_instr, slot_prev;
    logic [NUM_SLOTS-1:0]   slot_prev_en, slot_clean;
    logic                   run;

    assign slot_instr[0]   = unpack_instr(in0_instr);
    assign slot_instr[1]   = unpack_instr(in1_instr);
    assign slot_prev[0]    = '0;
    assign slot_prev_en[0] = 1'b0;
    // slot 1 can only issue alongside slot 0, so slot 0 is always its partner
    assign slot_prev[1]    = slot_instr[0];
    assign slot_prev_en[1] = 1'b1;

    always_comb begin
        wb_mask = '0;
        for (int r = 0; r < NREGS; r++)
            wb_mask[r] = (wb0_valid && wb0_rd == REG_IDX_W'(r)) ||
                         (wb1_valid && wb1_rd == REG_IDX_W'(r));
    end

    assign eff_busy = (WB_BYPASS != 0) ? (busy_vec & ~wb_mask) : busy_vec;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        issue_slot_check #(.NREGS(NREGS)) u_chk (
            .busy    (eff_busy),
            .instr   (slot_instr[s]),
            .prev_en (slot_prev_en[s]),
            .prev    (slot_prev[s]),
            .clean   (slot_clean[s])
        );
    end

    assign run    = (state == ST_RUN) && !is_branch_taken;
    assign issue0 = in0_valid && run && slot_clean[0];
    assign issue1 = issue0 && in1_valid && slot_clean[1];
    assign flush  = (state == ST_FLUSH) || is_branch_taken;
    assign stall  = !flush && ((in0_valid && !issue0) || (in1_valid && !issue1));

    always_comb begin
        set_mask = '0;
        for (int r = 0; r < NREGS; r++)
            set_mask[r] = (issue0 && writes_rd(slot_instr[0].opc) && slot_instr[0].rd == REG_IDX_W'(r)) ||
                          (issue1 && writes_rd(slot_instr[1].opc) && slot_instr[1].rd == REG_IDX_W'(r));
    end

    // set after clear: a new writer owns the register even if an old one retires now
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_vec <= '0;
        else        busy_vec <= (busy_vec & ~wb_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          stall_cycles <= '0;
        else if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (is_branch_taken) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= 3'(FLUSH_CYCLES);
                    end
                end
                ST_FLUSH: begin
                    if (is_branch_taken) begin
                        flush_cnt <= 3'(FLUSH_CYCLES);
                    end else if (flush_cnt <= 3'd1) begin
                        state     <= ST_RUN;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_issue_scoreboard_ctrl.sv
// Directed bench for dual_issue_scoreboard_ctrl with hand-computed expectations.
module tb_dual_issue_scoreboard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in0_valid, in1_valid, is_branch_taken;
    logic [15:0] in0_instr, in1_instr;
    logic        wb0_valid, wb1_valid;
    logic [2:0]  wb0_rd, wb1_rd;
    logic        issue0, issue1, stall, flush;
    logic [7:0]  busy_vec;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dual_issue_scoreboard_ctrl dut (
        .clk(clk), .reset(reset),
        .in0_valid(in0_valid), .in0_instr(in0_instr),
        .in1_valid(in1_valid), .in1_instr(in1_instr),
        .is_branch_taken(is_branch_taken),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
        .issue0(issue0), .issue1(issue1), .stall(stall), .flush(flush),
        .busy_vec(busy_vec), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic imm,
                                       input logic [2:0] rd, input logic [2:0] rs1,
                                       input logic [2:0] rs2);
        return {op, imm, rd, rs1, rs2, 2'b00};
    endfunction

    task automatic idle();
        in0_valid = 0; in1_valid = 0; in0_instr = '0; in1_instr = '0;
        is_branch_taken = 0; wb0_valid = 0; wb1_valid = 0; wb0_rd = '0; wb1_rd = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 0;
        idle();
        #12;
        chk("rst_busy", busy_vec, 8'h00);
        chk("rst_sc", stall_cycles, 16'h0);
        chk("rst_outs", {issue0, issue1, stall, flush}, 4'b0000);
        @(negedge clk);
        reset = 1;

        // ADD r1,r2,r3 alone
        in0_valid = 1; in0_instr = mk(4'h1, 0, 3'd1, 3'd2, 3'd3);
        #1 chk("add_issue", {issue0, stall}, 2'b10);
        step(); idle();
        chk("add_busy", busy_vec, 8'h02);

        // reader of busy r1 stalls, then bypassed writeback frees it
        in0_valid = 1; in0_instr = mk(4'h1, 0, 3'd6, 3'd1, 3'd0);
        #1 chk("raw_stall", {issue0, stall}, 2'b01);
        @(negedge clk);
        chk("raw_sc", stall_cycles, 16'd1);
        wb0_valid = 1; wb0_rd = 3'd1;
        #1 chk("wb_bypass", {issue0, stall}, 2'b10);
        step(); idle();
        chk("wb_busy", busy_vec, 8'h40);
        chk("wb_sc", stall_cycles, 16'd1);

        // intra-pair RAW on r4
        in0_valid = 1; in0_instr = mk(4'h1, 1, 3'd4, 3'd0, 3'd0);
        in1_valid = 1; in1_instr = mk(4'h1, 1, 3'd7, 3'd4, 3'd0);
        #1 chk("pair_raw", {issue0, issue1, stall}, 3'b101);
        step(); idle();
        chk("pair_busy", busy_vec, 8'h50);
        chk("pair_sc", stall_cycles, 16'd2);

        // independent pair dual-issues
        in0_valid = 1; in0_instr = mk(4'h1, 1, 3'd2, 3'd0, 3'd0);
        in1_valid = 1; in1_instr = mk(4'h1, 1, 3'd3, 3'd0, 3'd0);
        #1 chk("pair_ok", {issue0, issue1, stall}, 3'b110);
        step(); idle();
        chk("dual_busy", busy_vec, 8'h5C);

        // branch in slot 0 blocks slot 1; both wb ports clear r2/r3
        in0_valid = 1; in0_instr = mk(4'hC, 1, 3'd0, 3'd0, 3'd0);
        in1_valid = 1; in1_instr = mk(4'h1, 1, 3'd3, 3'd0, 3'd0);
        wb0_valid = 1; wb0_rd = 3'd2; wb1_valid = 1; wb1_rd = 3'd3;
        #1 chk("br_slot1", {issue0, issue1, stall}, 3'b101);
        step(); idle();
        chk("br_busy", busy_vec, 8'h50);
        chk("br_sc", stall_cycles, 16'd3);

        // branch taken: bubble for 1+FLUSH_CYCLES cycles
        in0_valid = 1; in0_instr = mk(4'h1, 1, 3'd1, 3'd0, 3'd0);
        in1_valid = 1; in1_instr = mk(4'h1, 1, 3'd2, 3'd0, 3'd0);
        is_branch_taken = 1;
        #1 chk("bt_cyc0", {issue0, issue1, stall, flush}, 4'b0001);
        step();
        is_branch_taken = 0; wb1_valid = 1; wb1_rd = 3'd4;
        #1 chk("bt_cyc1", {issue0, issue1, stall, flush}, 4'b0001);
        step(); idle();
        #1 chk("bt_done", flush, 1'b0);
        chk("bt_busy", busy_vec, 8'h40);
        chk("bt_sc", stall_cycles, 16'd3);

        // issue sets r5 while wb0 clears r5: set wins
        in0_valid = 1; in0_instr = mk(4'h1, 1, 3'd5, 3'd0, 3'd0);
        wb0_valid = 1; wb0_rd = 3'd5;
        #1 chk("setwin_iss", issue0, 1'b1);
        step(); idle();
        chk("setwin_busy", busy_vec, 8'h60);

        // both wb ports name r6
        wb0_valid = 1; wb0_rd = 3'd6; wb1_valid = 1; wb1_rd = 3'd6;
        step(); idle();
        chk("dup_wb", busy_vec, 8'h20);

        // STORE sources rd: busy r5 blocks it
        in0_valid = 1; in0_instr = mk(4'hB, 1, 3'd5, 3'd0, 3'd0);
        #1 chk("store_rd", {issue0, stall}, 2'b01);
        repeat (65600) @(posedge clk);
        @(negedge clk);
        chk("sat_sc", stall_cycles, 16'hFFFF);
        idle();

        // branch, reload during FLUSH, then reset mid-FLUSH
        is_branch_taken = 1;
        step();
        #1 chk("rl_flush0", flush, 1'b1);
        step();
        is_branch_taken = 0;
        #1 chk("rl_flush1", {flush, stall}, 2'b10);
        reset = 0;
        #1 chk("mid_rst", {issue0, issue1, stall, flush}, 4'b0000);
        chk("mid_rst_busy", busy_vec, 8'h00);
        chk("mid_rst_sc", stall_cycles, 16'h0);
        @(negedge clk);
        reset = 1;
        in0_valid = 1; in0_instr = mk(4'h1, 1, 3'd5, 3'd0, 3'd0);
        #1 chk("post_rst_run", {issue0, flush}, 2'b10);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
